bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised round-robin arbiter for the shared serial system bus. It generalises the fixed two-master priority arbitration to NUM_MASTERS masters.
- Adds grant hold until transaction completion, a programmable turnaround gap and abort detection.
- Sits between the master ports and the bus mux in top_level. Its grant_idx drives the address/data/control mux select.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..16).
- TURN_CYCLES, 1, idle bus cycles inserted after every release (0..15).
- TIMEOUT_CYCLES, 1024, max cycles a grant may be held (used only with ARB_TIMEOUT_EN).
- IDX_W, $clog2(NUM_MASTERS) (min 1), width of grant_idx.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held high until the transaction ends.
- tx_done  in  1  one-cycle pulse from the bus/slave side: the granted transaction completed.
- grant  out  NUM_MASTERS  one-hot grant, all zero when no master owns the bus.
- grant_idx  out  IDX_W  binary index of the granted master; holds its last value when grant==0.
- bus_busy  out  1  high while in BUSY or TURN.
- abort  out  1  one-cycle pulse: the granted master dropped m_req before tx_done.
- timeout  out  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, grant=0, grant_idx=0, bus_busy=0, abort=0, timeout=0, last=NUM_MASTERS-1, so master 0 has highest priority first.
- Reset mid-transaction drops grant immediately, without waiting for a clock edge.
- States: IDLE, BUSY, TURN.
- IDLE: if |m_req at edge k, go to BUSY at edge k.
  - grant is asserted from cycle k+1 (one-cycle latency).
  - Winner: first set bit of m_req searching from (last+1) mod NUM_MASTERS upward, with wrap-around.
  - last <= winner.
- BUSY: grant and grant_idx are held constant.
  - tx_done=1: release. Goes to TURN, or to IDLE if TURN_CYCLES==0.
  - m_req[granted]=0 with tx_done=0: release plus a one-cycle abort pulse.
  - tx_done=1 and m_req[granted]=0 in the same cycle: normal release, no abort.
  - tx_done while in IDLE/TURN: ignored.
- TURN: grant=0, bus_busy=1.
  - Counter loads TURN_CYCLES-1 on entry and decrements.
  - At 0, goes to IDLE.
  - Requests arriving during TURN are held pending, not lost; arbitration occurs in IDLE.
- Fairness: the releasing master has lowest priority at the next arbitration.
  - If it is the only requester, it wins again after the turnaround.
  - Worst-case wait for any requester: (NUM_MASTERS-1) transactions.
- NUM_MASTERS==1: grant_idx is constant 0; behaviour is otherwise identical.
- The grant output is registered and always one-hot or zero. The verification bench asserts this every cycle.
- With TURN_CYCLES==0, back-to-back grants to different masters need one IDLE cycle. Release edge k is followed by IDLE at k+1 and the new grant from k+2.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without tx_done, the arbiter force-releases to TURN and pulses timeout for one cycle.
  - tx_done in that same cycle wins: normal release, no timeout.
- Undefined: no counter is built, timeout is tied 0, and a grant may be held indefinitely.

Decomposition:
- Package bus_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, TURN=2'd2);
  - the clog2 function;
  - the default TURN_CYCLES/TIMEOUT_CYCLES constants shared with top_level.
- Sub-module rr_picker: purely combinational. Takes req and last, returns a one-hot winner and its index via a double-width rotate-and-priority search.
- bus_arbiter_rr holds the FSM, counters and output registers.

Test Plan:
1. Reset held low, then released; m_req=2'b11 at the first edge -> grant=2'b01, grant_idx=0 one cycle later. After tx_done: TURN for 1 cycle, then grant=2'b10.
2. NUM_MASTERS=4, m_req=4'b1111 held, tx_done pulsed each time BUSY is entered -> grant sequence 0001,0010,0100,1000,0001 with exactly one TURN cycle between grants.
3. Master 1 granted; m_req[1] dropped with no tx_done -> abort pulses for 1 cycle, grant=0 on the next cycle, then master 0 is granted if it is requesting.
4. tx_done and m_req[granted] fall in the same cycle -> abort stays 0 and the release is normal. Also pulse tx_done in IDLE -> no state change.
5. reset driven low mid-BUSY, between clock edges -> grant=0 and bus_busy=0 immediately. After reset release, master 0 has priority again.
6. ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, master 0 holds m_req with no tx_done -> timeout pulses in the 8th BUSY cycle, grant drops next cycle, and master 1 is granted after the turnaround.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// a width helper and the default timing constants used by top_level.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  localparam int DEF_TURN_CYCLES    = 1;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Ceiling log2, never smaller than 1 so single-bit indices stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin winner search. The request vector is doubled,
// rotated so the search starts just above the previous winner, and the
// lowest set bit of the rotated window is mapped back to a master index.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_start;
  int             w_pos;
  int             w_win;

  // Rotate-and-priority search starting at (last+1) mod N.
  always_comb begin
    w_start = int'(i_last) + 1;
    if (w_start >= N) w_start = 0;
    w_dbl   = {i_req, i_req};
    w_rot   = N'(w_dbl >> w_start);
    o_valid = |w_rot;
    w_pos   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = i;
    end
    w_win = w_start + w_pos;
    if (w_win >= N) w_win = w_win - N;
    o_idx    = IDX_W'(w_win);
    o_onehot = o_valid ? (N'(1) << w_win) : '0;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared serial system bus. Grants are held
// until tx_done, followed by a programmable turnaround gap. A granted master
// dropping its request early is reported as an abort.
// Optional feature: define ARB_TIMEOUT_EN to force-release grants held for
// TIMEOUT_CYCLES bus cycles; otherwise o_timeout is tied low.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TURN_CYCLES    = DEF_TURN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int IDX_W          = clog2(NUM_MASTERS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_MASTERS-1:0] i_m_req,
  input  logic                   i_tx_done,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [IDX_W-1:0]       o_grant_idx,
  output logic                   o_bus_busy,
  output logic                   o_abort,
  output logic                   o_timeout
);

  localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [IDX_W-1:0]       r_grant_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [IDX_W-1:0]       r_last;
  logic [IDX_W-1:0]       w_last_nxt;
  logic [3:0]             r_turn_cnt;
  logic [3:0]             w_turn_nxt;
  logic                   w_release;
  logic                   w_abort;
  logic                   w_req_granted;
  logic [NUM_MASTERS-1:0] w_pick_onehot;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int               HOLD_W   = clog2(TIMEOUT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIMEOUT_CYCLES - 1);
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_timeout;
`endif

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req    (i_m_req),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_req_granted = |(i_m_req & r_grant);

  // Next-state, next-grant and release/abort decode for the IDLE/BUSY/TURN FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_grant_idx;
    w_last_nxt  = r_last;
    w_turn_nxt  = r_turn_cnt;
    w_release   = 1'b0;
    w_abort     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_pick_onehot;
          w_idx_nxt   = w_pick_idx;
          w_last_nxt  = w_pick_idx;
        end
      end
      BUSY: begin
        if (i_tx_done) begin
          w_release = 1'b1;
        end else if (!w_req_granted) begin
          w_release = 1'b1;
          w_abort   = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold_cnt == HOLD_MAX) begin
          w_release = 1'b1;
          w_timeout = 1'b1;
        end
`endif
        if (w_release) begin
          w_grant_nxt = '0;
          if (TURN_CYCLES == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = TURN;
            w_turn_nxt  = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (r_turn_cnt == 4'd0) w_state_nxt = IDLE;
        else                    w_turn_nxt  = r_turn_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant and turnaround registers; reset drops the grant at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last      <= IDX_W'(NUM_MASTERS - 1);
      r_turn_cnt  <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_idx_nxt;
      r_last      <= w_last_nxt;
      r_turn_cnt  <= w_turn_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter: zero outside BUSY, counts each cycle the grant is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_hold_cnt <= '0;
    else if (r_state != BUSY)   r_hold_cnt <= '0;
    else                        r_hold_cnt <= r_hold_cnt + 1'b1;
  end
  assign o_timeout = w_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_grant     = r_grant;
  assign o_grant_idx = r_grant_idx;
  assign o_bus_busy  = (r_state != IDLE);
  assign o_abort     = w_abort;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a 2-master, a 4-master and a 3-master
// (three-cycle turnaround) instance share clock and reset. Expected values
// are worked out by hand cycle by cycle. Timeout checks follow ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;

  logic [1:0] req2, g2;
  logic       tx2, busy2, ab2, to2;
  logic [0:0] idx2;

  logic [3:0] req4, g4;
  logic       tx4, busy4, ab4, to4;
  logic [1:0] idx4;

  logic [2:0] req3, g3;
  logic       tx3, busy3, ab3, to3;
  logic [1:0] idx3;

  int checkCount = 0;
  int errorCount = 0;

  logic [3:0] rrExp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  bus_arbiter_rr #(.NUM_MASTERS(2), .TURN_CYCLES(1), .TIMEOUT_CYCLES(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req2), .i_tx_done(tx2),
    .o_grant(g2), .o_grant_idx(idx2), .o_bus_busy(busy2), .o_abort(ab2), .o_timeout(to2)
  );

  bus_arbiter_rr #(.NUM_MASTERS(4), .TURN_CYCLES(1), .TIMEOUT_CYCLES(64)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req4), .i_tx_done(tx4),
    .o_grant(g4), .o_grant_idx(idx4), .o_bus_busy(busy4), .o_abort(ab4), .o_timeout(to4)
  );

  bus_arbiter_rr #(.NUM_MASTERS(3), .TURN_CYCLES(3), .TIMEOUT_CYCLES(64)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(req3), .i_tx_done(tx3),
    .o_grant(g3), .o_grant_idx(idx3), .o_bus_busy(busy3), .o_abort(ab3), .o_timeout(to3)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive request/tx_done of the selected instance
  task automatic applyStimulus(input int which, input logic [3:0] req, input logic tx);
    case (which)
      2: begin req2 = req[1:0]; tx2 = tx; end
      3: begin req3 = req[2:0]; tx3 = tx; end
      default: begin req4 = req; tx4 = tx; end
    endcase
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Grants must be one-hot or zero in every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("onehot_g2", 32'($onehot0(g2)), 32'd1);
      checkOutput("onehot_g4", 32'($onehot0(g4)), 32'd1);
      checkOutput("onehot_g3", 32'($onehot0(g3)), 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0;
    req2 = '0; tx2 = 1'b0;
    req4 = '0; tx4 = 1'b0;
    req3 = '0; tx3 = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    checkOutput("rst_g2",    32'(g2),    32'd0);
    checkOutput("rst_idx2",  32'(idx2),  32'd0);
    checkOutput("rst_busy2", 32'(busy2), 32'd0);
    checkOutput("rst_ab2",   32'(ab2),   32'd0);
    checkOutput("rst_to2",   32'(to2),   32'd0);
    checkOutput("rst_g4",    32'(g4),    32'd0);
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_g3",    32'(g3),    32'd0);

    // Both masters request at the first edge: master 0 first
    applyStimulus(2, 4'b0011, 1'b0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("t1_g_first",  32'(g2),    32'h1);
    checkOutput("t1_idx",      32'(idx2),  32'd0);
    checkOutput("t1_busy",     32'(busy2), 32'd1);
    applyStimulus(2, 4'b0011, 1'b1);
    nextCycle();
    checkOutput("t1_turn_g",    32'(g2),    32'h0);
    checkOutput("t1_turn_busy", 32'(busy2), 32'd1);
    applyStimulus(2, 4'b0011, 1'b0);
    nextCycle();
    checkOutput("t1_idle_busy", 32'(busy2), 32'd0);
    checkOutput("t1_idle_idx",  32'(idx2),  32'd0);
    nextCycle();
    checkOutput("t1_g_second", 32'(g2),   32'h2);
    checkOutput("t1_idx2",     32'(idx2), 32'd1);

    // Master 1 drops its request without tx_done: abort
    applyStimulus(2, 4'b0001, 1'b0);
    #1;
    checkOutput("t3_abort",   32'(ab2), 32'd1);
    nextCycle();
    checkOutput("t3_g_drop",  32'(g2),    32'h0);
    checkOutput("t3_ab_once", 32'(ab2),   32'd0);
    checkOutput("t3_busy",    32'(busy2), 32'd1);
    nextCycle();
    nextCycle();
    checkOutput("t3_g_m0",    32'(g2),   32'h1);
    checkOutput("t3_idx_m0",  32'(idx2), 32'd0);

    // tx_done and request drop together: normal release, no abort
    applyStimulus(2, 4'b0000, 1'b1);
    #1;
    checkOutput("t4_no_abort", 32'(ab2), 32'd0);
    nextCycle();
    checkOutput("t4_g_rel",    32'(g2),    32'h0);
    checkOutput("t4_turn",     32'(busy2), 32'd1);
    applyStimulus(2, 4'b0000, 1'b0);
    nextCycle();
    // tx_done in IDLE has no effect
    applyStimulus(2, 4'b0000, 1'b1);
    nextCycle();
    checkOutput("t4_idle_tx_busy", 32'(busy2), 32'd0);
    checkOutput("t4_idle_tx_g",    32'(g2),    32'h0);
    // Sole requester wins again even though it owned the bus last
    applyStimulus(2, 4'b0001, 1'b0);
    nextCycle();
    checkOutput("t4_sole_again", 32'(g2), 32'h1);

    // Reset asserted between edges mid-BUSY
    applyStimulus(2, 4'b0011, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_g",    32'(g2),    32'h0);
    checkOutput("t5_async_busy", 32'(busy2), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("t5_m0_prio", 32'(g2),   32'h1);
    checkOutput("t5_idx",     32'(idx2), 32'd0);
    applyStimulus(2, 4'b0000, 1'b1);
    nextCycle();
    applyStimulus(2, 4'b0000, 1'b0);
    nextCycle();

    // Master 0 holds the bus with no tx_done
    applyStimulus(2, 4'b0001, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      nextCycle();
      if (i == 1) applyStimulus(2, 4'b0011, 1'b0);
      checkOutput("t6_hold_g", 32'(g2), 32'h1);
      #1;
      checkOutput("t6_timeout", 32'(to2), 32'(TIMEOUT_ON && (i == 8)));
    end
`ifdef ARB_TIMEOUT_EN
    nextCycle();
    checkOutput("t6_forced_g",  32'(g2),    32'h0);
    checkOutput("t6_to_once",   32'(to2),   32'd0);
    checkOutput("t6_turn_busy", 32'(busy2), 32'd1);
    nextCycle();
    nextCycle();
    checkOutput("t6_next_m1", 32'(g2), 32'h2);
    applyStimulus(2, 4'b0000, 1'b1);
    nextCycle();
    applyStimulus(2, 4'b0000, 1'b0);
    nextCycle();
`else
    nextCycle();
    checkOutput("t6_still_held", 32'(g2),  32'h1);
    checkOutput("t6_to_tied",    32'(to2), 32'd0);
    applyStimulus(2, 4'b0000, 1'b1);
    nextCycle();
    applyStimulus(2, 4'b0000, 1'b0);
    nextCycle();
`endif

    // Four masters all requesting: strict rotation with one TURN cycle
    applyStimulus(4, 4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checkOutput("t2_grant", 32'(g4),    32'(rrExp[k]));
      checkOutput("t2_idx",   32'(idx4),  32'(k % 4));
      checkOutput("t2_busy",  32'(busy4), 32'd1);
      applyStimulus(4, 4'b1111, 1'b1);
      nextCycle();
      checkOutput("t2_turn_g",    32'(g4),    32'h0);
      checkOutput("t2_turn_busy", 32'(busy4), 32'd1);
      applyStimulus(4, 4'b1111, 1'b0);
      nextCycle();
      checkOutput("t2_idle_busy", 32'(busy4), 32'd0);
      checkOutput("t2_no_abort",  32'(ab4),   32'd0);
    end
    // Requesters 0 and 2 after master 0 released: 2 then wrap to 0
    applyStimulus(4, 4'b0101, 1'b0);
    nextCycle();
    checkOutput("t2_skip_g", 32'(g4),   32'h4);
    checkOutput("t2_skip_i", 32'(idx4), 32'd2);
    applyStimulus(4, 4'b0101, 1'b1);
    nextCycle();
    applyStimulus(4, 4'b0101, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("t2_wrap_g", 32'(g4),  32'h1);
    checkOutput("t2_to_tied", 32'(to4), 32'd0);
    applyStimulus(4, 4'b0000, 1'b1);
    nextCycle();
    applyStimulus(4, 4'b0000, 1'b0);

    // Three-cycle turnaround; request raised during TURN stays pending
    applyStimulus(3, 4'b0010, 1'b0);
    nextCycle();
    checkOutput("t7_g", 32'(g3), 32'h2);
    applyStimulus(3, 4'b0010, 1'b1);
    for (int t = 0; t < 3; t++) begin
      nextCycle();
      if (t == 0) applyStimulus(3, 4'b0101, 1'b0);
      checkOutput("t7_turn_busy", 32'(busy3), 32'd1);
      checkOutput("t7_turn_g",    32'(g3),    32'h0);
    end
    nextCycle();
    checkOutput("t7_idle_busy", 32'(busy3), 32'd0);
    nextCycle();
    checkOutput("t7_pending_g", 32'(g3),   32'h4);
    checkOutput("t7_pending_i", 32'(idx3), 32'd2);
    checkOutput("t7_ab_to",     32'({ab3, to3}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
